fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage with a prefetch queue, for the pipelined core. It generates sequential PCs and issues requests to a one-cycle-latency synchronous instruction memory. Returned words are buffered with their next-PC in a DEPTH-entry queue and presented to decode over a valid/ready handshake. A taken branch or jump from EX/MEM redirects the PC, flushes the queue and squashes any response still in flight.

## Interface
- XLEN, 32, width of PC, addresses and instruction words
- DEPTH, 4, prefetch queue entries (≥2; ≥3 for one fetch per cycle)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- PC_INC, 4, sequential PC increment
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  asynchronous, active-low reset
- redirect  in  1  taken branch/jump from EX/MEM
- redirect_pc  in  XLEN  target address, sampled when redirect=1
- imem_req  out  1  read request this cycle
- imem_addr  out  XLEN  request address (current PC)
- imem_rdata  in  XLEN  data for the request issued in the previous cycle
- out_valid  out  1  queue head holds an instruction
- out_ready  in  1  decode accepts the head this cycle
- out_instr  out  XLEN  head instruction word
- out_npc  out  XLEN  head PC + PC_INC

## Operation
- State: pc register, queue (instr, npc, wr/rd pointers, count), inflight flag, inflight_npc.
- Request: imem_req = reset deasserted AND !redirect AND (count + inflight) < DEPTH. When a request is issued: imem_addr = pc, pc ← pc + PC_INC, inflight ← 1, inflight_npc ← pc + PC_INC. Otherwise inflight ← 0.
- Response: if inflight=1 in a cycle, push {imem_rdata, inflight_npc}. The occupancy rule guarantees there is space.
- Pop: on out_valid && out_ready, rd pointer advances. Push and pop in the same cycle leave count unchanged.
- Redirect (priority over request, push and pop):
  - pc ← redirect_pc.
  - count and pointers reset to empty.
  - inflight ← 0, and that cycle's imem_rdata is discarded.
  - imem_req = 0 in the redirect cycle.
- out_valid = (count != 0). out_instr and out_npc come from the head entry.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- PC arithmetic is modulo 2^XLEN, with no trap on overflow.
- Reset (asynchronous, any time, including mid-flight) sets:
  - pc = RESET_PC
  - count = 0 and pointers = 0
  - inflight = 0
  - all queue entries = 0
  - imem_req = 0, out_valid = 0, out_instr = 0, out_npc = 0

## Timing
- First request is in the first clock after reset deasserts, at address RESET_PC. out_valid rises 2 cycles after that request.
- Fetch latency: a request in cycle r has its data at imem_rdata in cycle r+1 and is visible at the queue head from cycle r+2 (if the queue was empty).
- Redirect in cycle t:
  - queue empty and out_valid = 0 from t+1
  - request to redirect_pc in t+1
  - out_valid in t+3 with out_npc = redirect_pc + PC_INC
- Throughput: with DEPTH ≥ 3 and out_ready held at 1, one instruction per cycle in steady state.
- Backpressure: with out_ready = 0, requests stop once count + inflight = DEPTH. out_instr and out_npc hold stable while out_valid=1 and out_ready=0.
- No combinational path from out_ready to imem_req.

## Structure
- Package fetch_pkg holds:
  - default XLEN
  - default PC_INC
  - default RESET_PC
  - the fetch_entry_t struct {instr, npc}
- Sub-module fetch_queue is a synchronous FIFO parametrised by DEPTH and entry width. It has push, pop and flush inputs and count, empty and full outputs.
- Top level holds the PC, the inflight tracking and the request/redirect control.

## Test plan
- Reset release, imem returns addr-derived words (rdata = addr ^ 32'hA5A5_0000), out_ready=1 → requests at 0x0, 0x4, 0x8, …. out_valid rises 2 cycles after the first request. Outputs are 0xA5A5_0000/npc 0x4, then 0xA5A5_0004/npc 0x8, at one per cycle.
- out_ready=0 from start, DEPTH=4 → exactly 4 requests (0x0–0xC), then imem_req=0. Raising out_ready drains 4 entries in order and fetching resumes at 0x10.
- Redirect to 0x100 while 3 entries are queued and a request is in flight → out_valid=0 next cycle, the stale response is dropped, request to 0x100 follows. The next out_npc is 0x104 and no old instruction appears.
- Redirect in the same cycle as pop and push → redirect wins, the queue is empty afterwards and the pushed data is lost.
- Reset asserted asynchronously mid-stream with the queue half full → all outputs 0 immediately. After release, fetch restarts at RESET_PC.
- PC wrap: redirect to 0xFFFF_FFFC → fetches 0xFFFF_FFFC, then 0x0000_0000. out_npc values are 0x0000_0000, then 0x0000_0004.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared defaults and the prefetch-queue entry layout for the fetch stage.
package fetch_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam int          PC_INC_DEFAULT   = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] instr;
        logic [XLEN_DEFAULT-1:0] npc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO for prefetched {instr, npc} entries; flush empties it in one cycle.
module fetch_queue #(
    parameter int   DEPTH = 4,
    parameter int   WIDTH = 64,
    localparam int  CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generation, one-cycle imem requests, prefetch queue, redirect flush.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int              PC_INC   = PC_INC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_npc
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_seq;
    logic              inflight;
    logic [XLEN-1:0]   inflight_npc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    logic              empty;
    logic              full;
    logic [2*XLEN-1:0] head;

    assign pc_seq    = pc + XLEN'(PC_INC);
    assign imem_addr = pc;

    // Reserve a slot for the in-flight word so a response can always be pushed.
    // Depends only on registered state, never on out_ready.
    assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight);
    assign imem_req  = reset && !redirect && !full
                       && (occupancy < (CNT_W + 1)'(DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc           <= RESET_PC;
            inflight     <= 1'b0;
            inflight_npc <= '0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else if (imem_req) begin
            pc           <= pc_seq;
            inflight     <= 1'b1;
            inflight_npc <= pc_seq;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (inflight && !redirect),
        .pop   (out_valid && out_ready && !redirect),
        .flush (redirect),
        .wdata ({imem_rdata, inflight_npc}),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    assign out_valid = !empty;
    assign out_instr = head[2*XLEN-1:XLEN];
    assign out_npc   = head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected {instr, npc}, a monitor pops and compares.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_npc;

    int           vectors = 0;
    int           miscompares = 0;
    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PC_INC(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_npc     (out_npc)
    );

    always #5 clk = ~clk;

    // One-cycle-latency instruction memory returning address-derived words.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] npc);
        fetch_entry_t e;
        e.instr = instr;
        e.npc   = npc;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A redirect cancels the handshake, so nothing is consumed in that cycle.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out: got instr %h npc %h, expected no output", out_instr, out_npc);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_instr", out_instr, mon_e.instr);
                check("out_npc", out_npc, mon_e.npc);
            end
        end
    end

    task automatic do_reset();
        reset     = 1'b0;
        redirect  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_imem_req", {31'b0, imem_req}, 32'h0);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_npc", out_npc, 32'h0);
        step();
        step();
        reset = 1'b1;
        #1;
    endtask

    task automatic drain(output int n);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check("drain_left", exp_q.size(), 32'h0);
        out_ready = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int reqs;

        // Sequential stream at full throughput
        do_reset();
        check("s1_req0", {31'b0, imem_req}, 32'h1);
        check("s1_addr0", imem_addr, 32'h0);
        check("s1_valid_c0", {31'b0, out_valid}, 32'h0);
        out_ready = 1'b1;
        push_exp(32'hA5A5_0000, 32'h0000_0004);
        push_exp(32'hA5A5_0004, 32'h0000_0008);
        push_exp(32'hA5A5_0008, 32'h0000_000C);
        push_exp(32'hA5A5_000C, 32'h0000_0010);
        push_exp(32'hA5A5_0010, 32'h0000_0014);
        push_exp(32'hA5A5_0014, 32'h0000_0018);
        step();
        check("s1_addr1", imem_addr, 32'h4);
        check("s1_valid_c1", {31'b0, out_valid}, 32'h0);
        step();
        check("s1_valid_c2", {31'b0, out_valid}, 32'h1);
        drain(n);
        check("s1_throughput", n, 32'd6);

        // Backpressure from the start
        do_reset();
        reqs = 0;
        for (int c = 0; c < 10; c++) begin
            if (imem_req) reqs++;
            step();
        end
        check("s2_req_count", reqs, 32'd4);
        check("s2_req_stopped", {31'b0, imem_req}, 32'h0);
        check("s2_pc_hold", imem_addr, 32'h10);
        check("s2_head_instr", out_instr, 32'hA5A5_0000);
        check("s2_head_npc", out_npc, 32'h4);
        push_exp(32'hA5A5_0000, 32'h0000_0004);
        push_exp(32'hA5A5_0004, 32'h0000_0008);
        push_exp(32'hA5A5_0008, 32'h0000_000C);
        push_exp(32'hA5A5_000C, 32'h0000_0010);
        push_exp(32'hA5A5_0010, 32'h0000_0014);
        push_exp(32'hA5A5_0014, 32'h0000_0018);
        out_ready = 1'b1;
        drain(n);

        // Redirect with 3 queued entries and one response in flight
        do_reset();
        step(); step(); step(); step();
        check("s3_valid_pre", {31'b0, out_valid}, 32'h1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        #1;
        check("s3_req_in_redirect", {31'b0, imem_req}, 32'h0);
        step();
        redirect = 1'b0;
        #1;
        check("s3_valid_t1", {31'b0, out_valid}, 32'h0);
        check("s3_req_t1", {31'b0, imem_req}, 32'h1);
        check("s3_addr_t1", imem_addr, 32'h100);
        push_exp(32'hA5A5_0100, 32'h0000_0104);
        push_exp(32'hA5A5_0104, 32'h0000_0108);
        push_exp(32'hA5A5_0108, 32'h0000_010C);
        out_ready = 1'b1;
        step();
        check("s3_valid_t2", {31'b0, out_valid}, 32'h0);
        drain(n);

        // Redirect coinciding with pop and push
        do_reset();
        out_ready = 1'b1;
        push_exp(32'hA5A5_0000, 32'h0000_0004);
        step(); step(); step();
        check("s4_valid_pre", {31'b0, out_valid}, 32'h1);
        check("s4_head_npc", out_npc, 32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        check("s4_req_in_redirect", {31'b0, imem_req}, 32'h0);
        step();
        redirect = 1'b0;
        #1;
        check("s4_valid_t1", {31'b0, out_valid}, 32'h0);
        push_exp(32'hA5A5_0200, 32'h0000_0204);
        push_exp(32'hA5A5_0204, 32'h0000_0208);
        drain(n);

        // Asynchronous reset mid-stream
        do_reset();
        step(); step(); step();
        check("s5_valid_pre", {31'b0, out_valid}, 32'h1);
        #3;
        reset = 1'b0;
        #1;
        check("s5_async_req", {31'b0, imem_req}, 32'h0);
        check("s5_async_valid", {31'b0, out_valid}, 32'h0);
        check("s5_async_instr", out_instr, 32'h0);
        check("s5_async_npc", out_npc, 32'h0);
        step();
        reset = 1'b1;
        #1;
        check("s5_restart_req", {31'b0, imem_req}, 32'h1);
        check("s5_restart_addr", imem_addr, 32'h0);
        push_exp(32'hA5A5_0000, 32'h0000_0004);
        push_exp(32'hA5A5_0004, 32'h0000_0008);
        out_ready = 1'b1;
        drain(n);

        // PC wrap-around
        do_reset();
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        check("s6_req_in_redirect", {31'b0, imem_req}, 32'h0);
        step();
        redirect = 1'b0;
        #1;
        check("s6_req_t1", {31'b0, imem_req}, 32'h1);
        check("s6_addr_top", imem_addr, 32'hFFFF_FFFC);
        step();
        check("s6_addr_wrap", imem_addr, 32'h0);
        push_exp(32'h5A5A_FFFC, 32'h0000_0000);
        push_exp(32'hA5A5_0000, 32'h0000_0004);
        push_exp(32'hA5A5_0004, 32'h0000_0008);
        drain(n);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
